// File: rtl/scarv_ccx_pkg.sv
// Shared definitions for the core complex interconnect (CCX).
// Provides requester index constants, the default starvation limit and a
// small helper that turns a requester index into a one-hot owner vector.
package scarv_ccx_pkg;

  // Requester indices as seen by the CCX arbiter.
  localparam logic CCX_REQ_IFETCH = 1'b0;
  localparam logic CCX_REQ_DATA   = 1'b1;

  // Default number of consecutive lost cycles before instruction fetch wins.
  localparam int unsigned CCX_STARVE_LIMIT = 4;

  // Lock state of the arbiter: free to re-arbitrate or holding a stalled choice.
  typedef enum logic {
    ARB_FREE = 1'b0,
    ARB_HELD = 1'b1
  } ccx_arb_lock_e;

  // Requester index to one-hot owner vector (bit N set for requester N).
  function automatic logic [1:0] ccx_onehot(input logic sel);
    logic [1:0] v;
    v = 2'b00;
    if (sel == CCX_REQ_DATA) begin
      v = 2'b10;
    end else begin
      v = 2'b01;
    end
    return v;
  endfunction

endpackage

// File: rtl/scarv_ccx_arb_starve.sv
// Starvation tracker for the low-priority (instruction fetch) requester.
// Counts consecutive cycles in which requester 0 asks but is not granted,
// saturating at STARVE_LIMIT. o_sat is a registered flag that is high while
// the counter sits at the limit; the arbiter combines it with the live
// request to force requester 0 to win. Only built when
// SCARV_CCX_ARB_STARVE_EN is defined.
module scarv_ccx_arb_starve
  import scarv_ccx_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = CCX_STARVE_LIMIT
) (
  input  logic       g_clk,
  input  logic       g_resetn,
  input  logic       i_req0,
  input  logic       i_gnt0,
  output logic       o_sat,
  output logic [3:0] o_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_cnt;
  logic       r_sat;
  logic [3:0] w_cnt_nxt;

  // Next count: increment while requester 0 waits, saturate, clear otherwise.
  always_comb begin
    w_cnt_nxt = 4'd0;
    if (i_req0 && !i_gnt0) begin
      if (r_cnt == LIMIT) begin
        w_cnt_nxt = r_cnt;
      end else begin
        w_cnt_nxt = r_cnt + 4'd1;
      end
    end else begin
      w_cnt_nxt = 4'd0;
    end
  end

  // Counter and saturation flag registers.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_cnt <= 4'd0;
      r_sat <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_sat <= (w_cnt_nxt == LIMIT);
    end
  end

  assign o_sat = r_sat;
  assign o_cnt = r_cnt;

endmodule

// File: rtl/scarv_ccx_ic_arbiter.sv
// Two-requester arbiter sharing one memif request port between the CPU
// instruction-fetch (requester 0, low priority) and data (requester 1, high
// priority) ports. The request path is combinational; the choice is frozen
// while the downstream port stalls, and the owner of each outstanding
// response is tracked so rdata/error reach only that requester.
// Optional feature macro: SCARV_CCX_ARB_STARVE_EN (starvation override for
// requester 0 after STARVE_LIMIT consecutive lost cycles).
module scarv_ccx_ic_arbiter
  import scarv_ccx_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = CCX_STARVE_LIMIT
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  // Requester 0: instruction fetch
  input  logic            if_req0_req,
  input  logic [AW-1:0]   if_req0_addr,
  input  logic            if_req0_wen,
  input  logic [DW/8-1:0] if_req0_strb,
  input  logic [DW-1:0]   if_req0_wdata,
  output logic            if_req0_gnt,
  output logic [DW-1:0]   if_req0_rdata,
  output logic            if_req0_error,
  // Requester 1: data access
  input  logic            if_req1_req,
  input  logic [AW-1:0]   if_req1_addr,
  input  logic            if_req1_wen,
  input  logic [DW/8-1:0] if_req1_strb,
  input  logic [DW-1:0]   if_req1_wdata,
  output logic            if_req1_gnt,
  output logic [DW-1:0]   if_req1_rdata,
  output logic            if_req1_error,
  // Shared downstream port
  output logic            if_dst_req,
  output logic [AW-1:0]   if_dst_addr,
  output logic            if_dst_wen,
  output logic [DW/8-1:0] if_dst_strb,
  output logic [DW-1:0]   if_dst_wdata,
  input  logic            if_dst_gnt,
  input  logic [DW-1:0]   if_dst_rdata,
  input  logic            if_dst_error,
  // Owner of the response due this cycle
  output logic [1:0]      arb_owner
);

  ccx_arb_lock_e r_lock;
  logic          r_lock_sel;
  logic [1:0]    r_rsp_own;

  ccx_arb_lock_e w_lock_nxt;
  logic          w_lock_sel_nxt;
  logic [1:0]    w_rsp_own_nxt;
  logic          w_sel;
  logic          w_force0;

`ifdef SCARV_CCX_ARB_STARVE_EN
  logic       w_starve_sat;
  logic [3:0] w_starve_cnt;

  scarv_ccx_arb_starve #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .i_req0   (if_req0_req),
    .i_gnt0   (if_req0_gnt),
    .o_sat    (w_starve_sat),
    .o_cnt    (w_starve_cnt)
  );

  // Override only while the counter is saturated and fetch is still asking.
  assign w_force0 = w_starve_sat && if_req0_req;
`else
  assign w_force0 = 1'b0;
`endif

  // Selection: a held lock wins, then the starvation override, then priority.
  always_comb begin
    w_sel = CCX_REQ_IFETCH;
    if (r_lock == ARB_HELD) begin
      w_sel = r_lock_sel;
    end else if (w_force0) begin
      w_sel = CCX_REQ_IFETCH;
    end else if (if_req1_req) begin
      w_sel = CCX_REQ_DATA;
    end else begin
      w_sel = CCX_REQ_IFETCH;
    end
  end

  // Request forwarding and grant return, purely combinational.
  always_comb begin
    if_dst_req   = 1'b0;
    if_dst_addr  = '0;
    if_dst_wen   = 1'b0;
    if_dst_strb  = '0;
    if_dst_wdata = '0;
    if (w_sel == CCX_REQ_DATA) begin
      if_dst_req   = if_req1_req;
      if_dst_addr  = if_req1_addr;
      if_dst_wen   = if_req1_wen;
      if_dst_strb  = if_req1_strb;
      if_dst_wdata = if_req1_wdata;
    end else begin
      if_dst_req   = if_req0_req;
      if_dst_addr  = if_req0_addr;
      if_dst_wen   = if_req0_wen;
      if_dst_strb  = if_req0_strb;
      if_dst_wdata = if_req0_wdata;
    end
    if_req0_gnt = if_dst_gnt && if_req0_req && (w_sel == CCX_REQ_IFETCH);
    if_req1_gnt = if_dst_gnt && if_req1_req && (w_sel == CCX_REQ_DATA);
  end

  // Next lock and response-owner state.
  always_comb begin
    w_lock_nxt     = ARB_FREE;
    w_lock_sel_nxt = r_lock_sel;
    w_rsp_own_nxt  = 2'b00;
    if (if_dst_req && !if_dst_gnt) begin
      w_lock_nxt     = ARB_HELD;
      w_lock_sel_nxt = w_sel;
    end else begin
      w_lock_nxt     = ARB_FREE;
      w_lock_sel_nxt = r_lock_sel;
    end
    if (if_dst_req && if_dst_gnt) begin
      w_rsp_own_nxt = ccx_onehot(w_sel);
    end else begin
      w_rsp_own_nxt = 2'b00;
    end
  end

  // Lock and response-owner registers; reset drops any outstanding response.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_lock     <= ARB_FREE;
      r_lock_sel <= CCX_REQ_IFETCH;
      r_rsp_own  <= 2'b00;
    end else begin
      r_lock     <= w_lock_nxt;
      r_lock_sel <= w_lock_sel_nxt;
      r_rsp_own  <= w_rsp_own_nxt;
    end
  end

  // Response steering: only the recorded owner sees rdata/error.
  always_comb begin
    if_req0_rdata = '0;
    if_req0_error = 1'b0;
    if_req1_rdata = '0;
    if_req1_error = 1'b0;
    if (r_rsp_own[1]) begin
      if_req1_rdata = if_dst_rdata;
      if_req1_error = if_dst_error;
    end else if (r_rsp_own[0]) begin
      if_req0_rdata = if_dst_rdata;
      if_req0_error = if_dst_error;
    end else begin
      if_req0_rdata = '0;
      if_req1_rdata = '0;
    end
  end

  assign arb_owner = r_rsp_own;

endmodule

// File: tb/tb_scarv_ccx_ic_arbiter.sv
// Directed self-checking bench for scarv_ccx_ic_arbiter.
// Inputs change on the falling clock edge; combinational outputs are checked
// 1 time unit later, registered outputs after the following rising edge.
module tb_scarv_ccx_ic_arbiter;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        r0_req, r1_req, d_req, r0_gnt, r1_gnt, d_gnt;
  logic [31:0] r0_addr, r1_addr, d_addr;
  logic        r0_wen, r1_wen, d_wen;
  logic [3:0]  r0_strb, r1_strb, d_strb;
  logic [31:0] r0_wdata, r1_wdata, d_wdata;
  logic [31:0] r0_rdata, r1_rdata, d_rdata;
  logic        r0_error, r1_error, d_error;
  logic [1:0]  owner;

  int errors = 0;
  int checks = 0;

  always #5 g_clk = ~g_clk;

  scarv_ccx_ic_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .if_req0_req(r0_req), .if_req0_addr(r0_addr), .if_req0_wen(r0_wen),
    .if_req0_strb(r0_strb), .if_req0_wdata(r0_wdata), .if_req0_gnt(r0_gnt),
    .if_req0_rdata(r0_rdata), .if_req0_error(r0_error),
    .if_req1_req(r1_req), .if_req1_addr(r1_addr), .if_req1_wen(r1_wen),
    .if_req1_strb(r1_strb), .if_req1_wdata(r1_wdata), .if_req1_gnt(r1_gnt),
    .if_req1_rdata(r1_rdata), .if_req1_error(r1_error),
    .if_dst_req(d_req), .if_dst_addr(d_addr), .if_dst_wen(d_wen),
    .if_dst_strb(d_strb), .if_dst_wdata(d_wdata), .if_dst_gnt(d_gnt),
    .if_dst_rdata(d_rdata), .if_dst_error(d_error),
    .arb_owner(owner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    g_resetn = 1'b0;
    r0_req = 1'b0; r0_addr = 32'h0; r0_wen = 1'b0; r0_strb = 4'h0; r0_wdata = 32'h0;
    r1_req = 1'b0; r1_addr = 32'h0; r1_wen = 1'b0; r1_strb = 4'h0; r1_wdata = 32'h0;
    d_gnt = 1'b0; d_rdata = 32'h0; d_error = 1'b0;

    // Reset state: no owner, zero responses, grant still combinational.
    #12;
    chk("rst_owner", {30'd0, owner}, 32'd0);
    r1_req = 1'b1; r1_addr = 32'h0001_0004; d_gnt = 1'b1; d_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rst_r1_gnt", {31'd0, r1_gnt}, 32'd1);
    chk("rst_r1_rdata", r1_rdata, 32'd0);
    chk("rst_r0_rdata", r0_rdata, 32'd0);

    // Single data request, response steered to requester 1.
    @(negedge g_clk);
    g_resetn = 1'b1; d_rdata = 32'h0;
    #1;
    chk("t1_r1_gnt", {31'd0, r1_gnt}, 32'd1);
    chk("t1_r0_gnt", {31'd0, r0_gnt}, 32'd0);
    chk("t1_dst_addr", d_addr, 32'h0001_0004);
    chk("t1_dst_req", {31'd0, d_req}, 32'd1);
    @(negedge g_clk);
    r1_req = 1'b0; d_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_owner", {30'd0, owner}, 32'h2);
    chk("t1_r1_rdata", r1_rdata, 32'hDEAD_BEEF);
    chk("t1_r0_rdata", r0_rdata, 32'd0);

    // Both request: data first, then fetch; alternating owners.
    @(negedge g_clk);
    r0_req = 1'b1; r0_addr = 32'h0000_0100; r1_req = 1'b1; r1_addr = 32'h0000_0200;
    #1;
    chk("t2_idle_owner", {30'd0, owner}, 32'd0);
    chk("t2_r1_gnt", {31'd0, r1_gnt}, 32'd1);
    chk("t2_r0_gnt", {31'd0, r0_gnt}, 32'd0);
    chk("t2_dst_addr", d_addr, 32'h0000_0200);
    @(negedge g_clk);
    r1_req = 1'b0; d_rdata = 32'h1111_1111;
    #1;
    chk("t2_owner_a", {30'd0, owner}, 32'h2);
    chk("t2_r1_rdata", r1_rdata, 32'h1111_1111);
    chk("t2_r0_gnt_b", {31'd0, r0_gnt}, 32'd1);
    chk("t2_dst_addr_b", d_addr, 32'h0000_0100);
    @(negedge g_clk);
    r0_req = 1'b0; d_rdata = 32'h2222_2222;
    #1;
    chk("t2_owner_b", {30'd0, owner}, 32'h1);
    chk("t2_r0_rdata", r0_rdata, 32'h2222_2222);
    chk("t2_r1_rdata_b", r1_rdata, 32'd0);

    // Downstream stall for 3 cycles; late data request must not pre-empt.
    @(negedge g_clk);
    r0_req = 1'b1; r0_addr = 32'h0000_0300; d_gnt = 1'b0;
    #1;
    chk("t3_c0_addr", d_addr, 32'h0000_0300);
    chk("t3_c0_r0_gnt", {31'd0, r0_gnt}, 32'd0);
    @(negedge g_clk);
    r1_req = 1'b1; r1_addr = 32'h0000_0400;
    #1;
    chk("t3_c1_addr", d_addr, 32'h0000_0300);
    chk("t3_c1_r1_gnt", {31'd0, r1_gnt}, 32'd0);
    @(negedge g_clk);
    #1;
    chk("t3_c2_addr", d_addr, 32'h0000_0300);
    @(negedge g_clk);
    d_gnt = 1'b1;
    #1;
    chk("t3_c3_r0_gnt", {31'd0, r0_gnt}, 32'd1);
    chk("t3_c3_r1_gnt", {31'd0, r1_gnt}, 32'd0);
    chk("t3_c3_addr", d_addr, 32'h0000_0300);

    // Data request now wins; then its error response goes only to requester 1.
    @(negedge g_clk);
    r0_req = 1'b0;
    #1;
    chk("t4_owner_f", {30'd0, owner}, 32'h1);
    chk("t4_r1_gnt", {31'd0, r1_gnt}, 32'd1);
    @(negedge g_clk);
    r1_req = 1'b0; d_error = 1'b1;
    #1;
    chk("t4_owner_d", {30'd0, owner}, 32'h2);
    chk("t4_r1_error", {31'd0, r1_error}, 32'd1);
    chk("t4_r0_error", {31'd0, r0_error}, 32'd0);

    // Continuous contention with grant always available.
    @(negedge g_clk);
    d_error = 1'b0; r0_req = 1'b1; r0_addr = 32'h0000_0500; r1_req = 1'b1; r1_addr = 32'h0000_0600;
`ifdef SCARV_CCX_ARB_STARVE_EN
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("t5_lose_%0d", i), {31'd0, r0_gnt}, 32'd0);
      @(negedge g_clk);
    end
    #1;
    chk("t5_win5_r0", {31'd0, r0_gnt}, 32'd1);
    chk("t5_win5_r1", {31'd0, r1_gnt}, 32'd0);
    @(negedge g_clk);
    #1;
    chk("t5_after_r1", {31'd0, r1_gnt}, 32'd1);
    chk("t5_after_cnt", {28'd0, dut.w_starve_cnt}, 32'd0);
`else
    for (int i = 1; i <= 6; i++) begin
      #1;
      chk($sformatf("t5_fixed_r0_%0d", i), {31'd0, r0_gnt}, 32'd0);
      chk($sformatf("t5_fixed_r1_%0d", i), {31'd0, r1_gnt}, 32'd1);
      @(negedge g_clk);
    end
`endif
    r0_req = 1'b0; r1_req = 1'b0;

    // Reset pulse between a grant and its response drops the response.
    @(negedge g_clk);
    r1_req = 1'b1; r1_addr = 32'h0000_0700; d_rdata = 32'hDEAD_BEEF;
    @(posedge g_clk);
    #1;
    r1_req = 1'b0;
    chk("t6_owner_pre", {30'd0, owner}, 32'h2);
    #1 g_resetn = 1'b0;
    #1;
    chk("t6_owner_rst", {30'd0, owner}, 32'd0);
    chk("t6_rdata_rst", r1_rdata, 32'd0);
    #1 g_resetn = 1'b1;
    @(negedge g_clk);
    #1;
    chk("t6_owner_post", {30'd0, owner}, 32'd0);
    chk("t6_rdata_post", r1_rdata, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scarv_ccx_ic_arbiter.md
# scarv_ccx_ic_arbiter

Two-requester arbiter for the core complex interconnect. It shares one `scarv_ccx_memif` request port between the CPU instruction-fetch and data-access ports and feeds the interconnect router. It holds its grant decision while a downstream request is stalled. It also tracks which requester owns each outstanding response and steers `rdata`/`error` back to that requester only.

## Interface
Parameters:
- `AW`, 32, address width (matches memif).
- `DW`, 32, data width (matches memif).
- `STARVE_LIMIT`, 4, number of consecutive lost cycles after which requester 0 is forced to win. Used only with the macro enabled; range 1..15.

Ports:
- `g_clk`  in  1  clock; all state on the rising edge.
- `g_resetn`  in  1  reset, asynchronous, active-low.
- `if_req0`  `scarv_ccx_memif.RSP`  —  requester 0: instruction fetch, low priority.
- `if_req1`  `scarv_ccx_memif.RSP`  —  requester 1: data access, high priority.
- `if_dst`  `scarv_ccx_memif.REQ`  —  shared downstream port to the router.
- `arb_owner`  out  2  one-hot requester whose response is due this cycle; `2'b00` means none.

## Operation
- State:
  - `lock` (1b) and `lock_sel` (1b): holds the selection while a request is stalled.
  - `rsp_own` (2b, one-hot): owner of the response due this cycle.
  - `starve_cnt` (4b): starvation counter, present only with the macro enabled.
- Selection `sel`:
  - If `lock`, `sel = lock_sel`.
  - Otherwise `sel = 1` if `if_req1.req`; `sel = 0` if only `if_req0.req`.
  - With the macro enabled, `sel = 0` whenever `starve_cnt == STARVE_LIMIT` and `if_req0.req`.
- Forwarding: `if_dst.{addr,wen,strb,wdata}` come from the selected requester. `if_dst.req` is the selected requester's `req`.
- Grant: `if_reqN.gnt = if_dst.gnt && if_reqN.req && sel == N`. The unselected requester sees `gnt = 0`.
- Lock update each cycle:
  - If `if_dst.req && !if_dst.gnt`: set `lock <= 1`, `lock_sel <= sel`.
  - Otherwise: set `lock <= 0`.
  - Requesters must hold `req` and payload stable until granted, per memif rules. If a locked requester drops `req` anyway, the lock clears next cycle.
- Response tracking: `rsp_own <= onehot(sel)` when `if_dst.req && if_dst.gnt`, else `2'b00`. `arb_owner = rsp_own`.
- Response steering:
  - The owner gets `if_dst.rdata` and `if_dst.error`.
  - The non-owner gets `rdata = 0` and `error = 0`.
  - When `rsp_own == 0`, both requesters see zeros.
- Starvation counter (macro enabled only):
  - Increments, saturating at `STARVE_LIMIT`, when `if_req0.req` is high and `if_req0.gnt` is low.
  - Clears when requester 0 is granted or `if_req0.req` is low.

## Timing
- Request path is combinational: zero added latency from requester to `if_dst`, and for `gnt` back.
- Response arrives one cycle after `req && gnt`. Back-to-back grants are supported, including alternating owners: a new grant in cycle N overlaps the response for cycle N-1.
- Reset values: `lock = 0`, `lock_sel = 0`, `rsp_own = 2'b00`, `starve_cnt = 0`.
- Outputs during reset: `arb_owner = 0`. Requester `rdata` and `error` are 0. `gnt` follows the combinational rules with `lock = 0`.
- Simultaneous requests with no lock: requester 1 wins, unless the starvation override applies.
- Reset asserted mid-transaction: the outstanding response is dropped and its data is not forwarded after reset releases.
- Downstream stall: selection is frozen for the whole stall. A higher-priority request arriving mid-stall does not pre-empt.

## Configuration
- `SCARV_CCX_ARB_STARVE_EN` defined:
  - The starvation counter and override are compiled in.
  - Requester 0 is guaranteed a grant at most `STARVE_LIMIT` cycles plus any downstream stall time after it requests.
- Not defined:
  - Pure fixed priority; requester 1 always wins unlocked contention.
  - `starve_cnt` does not exist and `STARVE_LIMIT` is ignored.

## Structure
- Shared package `scarv_ccx_pkg`:
  - requester index constants `CCX_REQ_IFETCH = 0` and `CCX_REQ_DATA = 1`;
  - the default `STARVE_LIMIT`.
- Sub-module `scarv_ccx_arb_starve` contains the saturating counter and the override flag. It is instantiated only under the macro.

## Test plan
- Only `if_req1` requests `addr = 0x0001_0004`, with `if_dst.gnt = 1` → `if_req1.gnt = 1` the same cycle. Next cycle, `arb_owner = 2'b10` and `if_req1.rdata` = downstream `rdata` (e.g. `0xDEADBEEF`), while `if_req0.rdata = 0`.
- Both request, with `if_dst.gnt = 1` → requester 1 is granted. Requester 0 is granted the following cycle once requester 1 drops `req`. Responses return with `arb_owner` of `2'b10` then `2'b01`.
- Requester 0 is selected and `if_dst.gnt` is held 0 for 3 cycles while `if_req1` asserts in cycle 1 → `if_dst.addr` stays requester 0's value throughout. Requester 0 is granted in cycle 3.
- Downstream `error = 1` on a data response → `if_req1.error = 1` and `if_req0.error = 0`.
- Macro enabled, `STARVE_LIMIT = 4`, both requesting continuously with `gnt = 1` → requester 0 is granted on the 5th cycle, then the counter resets to 0.
- `g_resetn` pulsed low asynchronously between a grant and its response → `arb_owner = 0` immediately, and no response is delivered after release.
